noc_vc_output_port: RTL and testbench

- Parametrised next-generation router output stage: N input ports contend for one output link toward a downstream router with per-VC credit-based flow control.
- Performs round-robin switch allocation with wormhole packet lock: the winner owns the link from SOP to EOP.
- Tracks downstream buffer credits per VC and registers the outgoing flit.
- One instance per active router output port; input count, VC count and downstream buffer depth are all generic.

---
 rtl/noc_vc_output_port_pkg.sv | 26 ++
 rtl/noc_vc_output_port_arbiter.sv | 60 ++++++
 rtl/noc_vc_output_port.sv | 263 ++++++++++++++++++++++++++
 tb/tb_noc_vc_output_port.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_vc_output_port_pkg.sv
// -----------------------------------------------------------------------------
// noc_vc_output_port_pkg
//
// Shared definitions for the router output-port slice:
//   Noc_Flit_Width      default flit width in bits
//   Noc_VC_Channel      default number of virtual channels on a link
//   noc_outport_state_e output-port allocation state (IDLE / LOCKED)
//   noc_idx_w()         index width for an N-entry selection, never below 1
// -----------------------------------------------------------------------------
package noc_vc_output_port_pkg;

  localparam int Noc_Flit_Width = 16;
  localparam int Noc_VC_Channel = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } noc_outport_state_e;

  // A one-entry selection still needs a one-bit index so that port and
  // register widths never collapse to zero.
  function automatic int noc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_vc_output_port_arbiter.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter
//
// Purely combinational round-robin arbiter. The search starts at i_ptr and
// wraps; the first asserted request found wins.
//
// Parameters:
//   NUM_IN   number of requesters
// Ports:
//   i_req    [NUM_IN-1:0]  request vector
//   i_ptr    [IDX_W-1:0]   highest-priority requester this cycle (< NUM_IN)
//   o_grant  [NUM_IN-1:0]  one-hot winner (zero when no request)
//   o_idx    [IDX_W-1:0]   binary index of the winner
//   o_valid                at least one request present
// -----------------------------------------------------------------------------
module noc_rr_arbiter
  import noc_vc_output_port_pkg::*;
#(
  parameter  int NUM_IN = 5,
  localparam int IDX_W  = noc_idx_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NUM_IN-1:0] o_grant,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_valid
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(NUM_IN);

  // Rotate the request vector so that bit 0 is the requester at i_ptr; a
  // fixed-priority search on the rotated vector then gives round-robin order.
  logic [NUM_IN-1:0] w_rot;
  logic [NUM_IN:0]   w_seen;
  logic [IDX_W-1:0]  w_off_acc [NUM_IN+1];
  logic [IDX_W:0]    w_sum;

  assign w_rot        = NUM_IN'({i_req, i_req} >> i_ptr);
  assign w_seen[0]    = 1'b0;
  assign w_off_acc[0] = '0;

  // w_seen[gi] says a lower rotated position already requested, so only the
  // first hit contributes its offset to the OR chain.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_search
    logic w_first;
    assign w_first          = w_rot[gi] & ~w_seen[gi];
    assign w_seen[gi+1]     = w_seen[gi] | w_rot[gi];
    assign w_off_acc[gi+1]  = w_off_acc[gi] | ({IDX_W{w_first}} & IDX_W'(gi));
  end

  // Undo the rotation: winner = (ptr + offset) mod NUM_IN.
  assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off_acc[NUM_IN]};
  assign o_idx   = IDX_W'((w_sum >= N_EXT) ? (w_sum - N_EXT) : w_sum);
  assign o_valid = w_seen[NUM_IN];

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_onehot
    assign o_grant[gi] = o_valid && (o_idx == IDX_W'(gi));
  end

endmodule

// File: rtl/noc_vc_output_port.sv
// -----------------------------------------------------------------------------
// noc_vc_output_port
//
// Router output stage: NUM_IN inputs compete for one downstream link that
// carries CHANNELS virtual channels with credit-based flow control. A
// round-robin winner locks the link from its head flit to its tail flit
// (wormhole). Accepted flits are registered one cycle before leaving.
//
// Optional build macro:
//   NOC_OUTPORT_CREDIT_CHK_EN  when defined, credit_err becomes a sticky flag
//                              raised by an over-return of credits or by a
//                              head flit appearing inside a packet already in
//                              flight. When undefined, credit_err is tied 0.
//
// Ports:
//   noc_clk, noc_rst       clock (rising edge), asynchronous active-high reset
//   in_req   [NUM_IN]      input i has a head flit for this output
//   in_vc    [NUM_IN*VC_W] downstream VC wanted by input i (slice i)
//   in_valid [NUM_IN]      input i presents a flit
//   in_sop / in_eop        presented flit is head / tail
//   in_flit  [NUM_IN*FLIT_W] flit data (slice i)
//   in_grant [NUM_IN]      one-hot packet owner, zero when idle
//   in_ready [NUM_IN]      flit on input i is accepted this cycle
//   out_valid/out_flit/out_vc  registered flit toward downstream
//   credit_return [CHANNELS]   one pulse per freed downstream slot on VC v
//   credit_avail  [CHANNELS]   VC v has at least one credit
//   credit_err                 sticky credit-protocol error
// -----------------------------------------------------------------------------
module noc_vc_output_port
  import noc_vc_output_port_pkg::*;
#(
  parameter  int NUM_IN       = 5,
  parameter  int CHANNELS     = Noc_VC_Channel,
  parameter  int FLIT_W       = Noc_Flit_Width,
  parameter  int CREDIT_DEPTH = 4,
  localparam int VC_W         = noc_idx_w(CHANNELS)
) (
  input  logic                     noc_clk,
  input  logic                     noc_rst,
  input  logic [NUM_IN-1:0]        in_req,
  input  logic [NUM_IN*VC_W-1:0]   in_vc,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN-1:0]        in_sop,
  input  logic [NUM_IN-1:0]        in_eop,
  input  logic [NUM_IN*FLIT_W-1:0] in_flit,
  output logic [NUM_IN-1:0]        in_grant,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [FLIT_W-1:0]        out_flit,
  output logic [VC_W-1:0]          out_vc,
  input  logic [CHANNELS-1:0]      credit_return,
  output logic [CHANNELS-1:0]      credit_avail,
  output logic                     credit_err
);

  localparam int                IDX_W    = noc_idx_w(NUM_IN);
  localparam int                CNT_W    = $clog2(CREDIT_DEPTH + 1);
  localparam int                VC_SPAN  = 1 << VC_W;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CREDIT_DEPTH);

  noc_outport_state_e r_state;
  noc_outport_state_e w_state_next;

  logic [IDX_W-1:0]          r_owner;
  logic [IDX_W-1:0]          r_rr_ptr;
  logic [VC_W-1:0]           r_owner_vc;
  logic                      r_out_valid;
  logic [FLIT_W-1:0]         r_out_flit;
  logic [VC_W-1:0]           r_out_vc;

  logic [VC_W-1:0]           w_vc   [NUM_IN];
  logic [FLIT_W-1:0]         w_flit [NUM_IN];
  logic [NUM_IN-1:0]         w_eligible;
  logic [CHANNELS*CNT_W-1:0] w_credit_flat;
  logic [CHANNELS-1:0]       w_dec;
  logic [VC_SPAN-1:0]        w_credit_ok_ext;
  logic                      w_owner_credit_ok;
  logic                      w_accept;
  logic                      w_release;

  logic [NUM_IN-1:0]         w_arb_grant;
  logic [IDX_W-1:0]          w_arb_idx;
  logic                      w_arb_vld;

  // ---------------------------------------------------------------------------
  // Per-input unpacking and eligibility
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_input
    assign w_vc[gi]       = in_vc[gi*VC_W +: VC_W];
    assign w_flit[gi]     = in_flit[gi*FLIT_W +: FLIT_W];
    // An input whose target VC has no credit is skipped so that a packet on
    // another VC can take the link instead of blocking behind it.
    assign w_eligible[gi] = in_req[gi] && w_credit_ok_ext[w_vc[gi]];
  end

  // Credit-available table padded to a power of two; VC codes beyond
  // CHANNELS read as "no credit" and can never win.
  for (genvar gi = 0; gi < VC_SPAN; gi++) begin : g_credit_ok
    if (gi < CHANNELS) begin : g_real
      assign w_credit_ok_ext[gi] = (w_credit_flat[gi*CNT_W +: CNT_W] != '0);
    end else begin : g_pad
      assign w_credit_ok_ext[gi] = 1'b0;
    end
  end

  assign credit_avail      = w_credit_ok_ext[CHANNELS-1:0];
  assign w_owner_credit_ok = w_credit_ok_ext[r_owner_vc];

  noc_rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_arb (
    .i_req   (w_eligible),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_vld)
  );

  // ---------------------------------------------------------------------------
  // Allocation FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_grant     = '0;
    in_ready     = '0;
    w_accept     = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_vld) begin
          w_state_next = LOCKED;
        end
      end
      LOCKED: begin
        // Only the tail flit ends ownership; in_req and in_sop of the owner
        // are ignored while locked.
        in_grant[r_owner] = 1'b1;
        if (in_valid[r_owner] && w_owner_credit_ok) begin
          in_ready[r_owner] = 1'b1;
          w_accept          = 1'b1;
          if (in_eop[r_owner]) begin
            w_release    = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Owner capture and round-robin pointer advance
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      r_owner    <= '0;
      r_owner_vc <= '0;
      r_rr_ptr   <= '0;
    end else begin
      if (r_state == IDLE && w_arb_vld) begin
        r_owner    <= w_arb_idx;
        r_owner_vc <= w_vc[w_arb_idx];
      end
      if (w_release) begin
        r_rr_ptr <= (r_owner == IDX_W'(NUM_IN - 1)) ? '0 : r_owner + 1'b1;
      end
    end
  end

  // Output flit register; the downstream never stalls, so every accepted
  // flit is presented for exactly one cycle.
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_out_vc    <= '0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_flit <= w_flit[r_owner];
        r_out_vc   <= r_owner_vc;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_flit  = r_out_flit;
  assign out_vc    = r_out_vc;

  // ---------------------------------------------------------------------------
  // Per-VC credit counters
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_credit
    logic [CNT_W-1:0] r_cnt;

    assign w_dec[gi] = w_accept && (r_owner_vc == VC_W'(gi));

    // A spend and a return in the same cycle cancel; a return into a full
    // counter is dropped rather than wrapping.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
        r_cnt <= CNT_FULL;
      end else if (w_dec[gi] && !credit_return[gi]) begin
        r_cnt <= r_cnt - 1'b1;
      end else if (!w_dec[gi] && credit_return[gi] && (r_cnt != CNT_FULL)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_credit_flat[gi*CNT_W +: CNT_W] = r_cnt;
  end

  // ---------------------------------------------------------------------------
  // Credit-protocol checker
  // ---------------------------------------------------------------------------
`ifdef NOC_OUTPORT_CREDIT_CHK_EN
  logic                r_credit_err;
  logic                r_pkt_started;
  logic [CHANNELS-1:0] w_over_return;
  logic                w_sop_violation;
  logic                w_unused;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_over
    assign w_over_return[gi] = credit_return[gi] && !w_dec[gi] &&
                               (w_credit_flat[gi*CNT_W +: CNT_W] == CNT_FULL);
  end

  // A head flit is legal only as the first flit of the locked packet.
  assign w_sop_violation = (r_state == LOCKED) && r_pkt_started &&
                           in_valid[r_owner] && in_sop[r_owner];

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      r_credit_err  <= 1'b0;
      r_pkt_started <= 1'b0;
    end else begin
      if ((|w_over_return) || w_sop_violation) begin
        r_credit_err <= 1'b1;
      end
      if (w_release) begin
        r_pkt_started <= 1'b0;
      end else if (w_accept) begin
        r_pkt_started <= 1'b1;
      end
    end
  end

  assign credit_err = r_credit_err;
  assign w_unused   = ^w_arb_grant;
`else
  logic w_unused;

  assign credit_err = 1'b0;
  assign w_unused   = ^{w_arb_grant, in_sop};
`endif

endmodule

// File: tb/tb_noc_vc_output_port.sv
// -----------------------------------------------------------------------------
// tb_noc_vc_output_port
//
// Directed bench for noc_vc_output_port (NUM_IN=5, CHANNELS=2, FLIT_W=16,
// CREDIT_DEPTH=4). Inputs change on the falling edge; outputs are sampled
// 1 ns later, i.e. well away from the rising edge. Expected values are
// worked out by hand from the cycle behaviour of the port.
// -----------------------------------------------------------------------------
module tb_noc_vc_output_port;

  logic        noc_clk = 1'b0;
  logic        noc_rst;
  logic [4:0]  in_req;
  logic [4:0]  in_vc;
  logic [4:0]  in_valid;
  logic [4:0]  in_sop;
  logic [4:0]  in_eop;
  logic [79:0] in_flit;
  logic [4:0]  in_grant;
  logic [4:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_flit;
  logic        out_vc;
  logic [1:0]  credit_return;
  logic [1:0]  credit_avail;
  logic        credit_err;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef NOC_OUTPORT_CREDIT_CHK_EN
  localparam logic EXP_OVER_ERR = 1'b1;
`else
  localparam logic EXP_OVER_ERR = 1'b0;
`endif

  always #5 noc_clk = ~noc_clk;

  noc_vc_output_port #(
    .NUM_IN       (5),
    .CHANNELS     (2),
    .FLIT_W       (16),
    .CREDIT_DEPTH (4)
  ) dut (
    .noc_clk       (noc_clk),
    .noc_rst       (noc_rst),
    .in_req        (in_req),
    .in_vc         (in_vc),
    .in_valid      (in_valid),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_flit       (in_flit),
    .in_grant      (in_grant),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_flit      (out_flit),
    .out_vc        (out_vc),
    .credit_return (credit_return),
    .credit_avail  (credit_avail),
    .credit_err    (credit_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Observed credit counter of VC v.
  function automatic logic [31:0] cred(input int v);
    logic [5:0] f;
    f = dut.w_credit_flat;
    return (v == 0) ? 32'(f[2:0]) : 32'(f[5:3]);
  endfunction

  task automatic clear_inputs();
    in_req   = '0;
    in_vc    = '0;
    in_valid = '0;
    in_sop   = '0;
    in_eop   = '0;
    in_flit  = '0;
  endtask

  task automatic drive(input int i, input logic req, input logic vld, input logic sop,
                       input logic eop, input logic vc, input logic [15:0] flit);
    logic [4:0]  m;
    logic [79:0] fm;
    m        = 5'b00001 << i;
    fm       = 80'hFFFF << (i * 16);
    in_req   = req ? (in_req   | m) : (in_req   & ~m);
    in_valid = vld ? (in_valid | m) : (in_valid & ~m);
    in_sop   = sop ? (in_sop   | m) : (in_sop   & ~m);
    in_eop   = eop ? (in_eop   | m) : (in_eop   & ~m);
    in_vc    = vc  ? (in_vc    | m) : (in_vc    & ~m);
    in_flit  = (in_flit & ~fm) | (80'(flit) << (i * 16));
  endtask

  task automatic do_reset();
    @(negedge noc_clk);
    noc_rst       = 1'b1;
    credit_return = '0;
    clear_inputs();
    @(negedge noc_clk);
    noc_rst = 1'b0;
  endtask

  // Expected fairness order: 0, 1, 4 repeating.
  function automatic int who(input int k);
    case (k % 3)
      0:       return 0;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    logic er;
    logic prev_er;

    noc_rst       = 1'b1;
    credit_return = '0;
    clear_inputs();
    repeat (2) @(negedge noc_clk);
    noc_rst = 1'b0;
    #1;
    check("rst_state",   32'(dut.r_state), 32'd0);
    check("rst_grant",   32'(in_grant),    32'd0);
    check("rst_ready",   32'(in_ready),    32'd0);
    check("rst_ovalid",  32'(out_valid),   32'd0);
    check("rst_oflit",   32'(out_flit),    32'd0);
    check("rst_ovc",     32'(out_vc),      32'd0);
    check("rst_cavail",  32'(credit_avail), 32'b11);
    check("rst_cred0",   cred(0),          32'd4);
    check("rst_cred1",   cred(1),          32'd4);
    check("rst_err",     32'(credit_err),  32'd0);

    // ---- single requester: input 2, VC1, 3 flits ----------------------------
    @(negedge noc_clk);
    drive(2, 1, 1, 1, 0, 1, 16'hA001);
    #1;
    check("s1_grant_t0", 32'(in_grant), 32'd0);
    check("s1_ready_t0", 32'(in_ready), 32'd0);
    @(negedge noc_clk); #1;
    check("s1_grant_t1",  32'(in_grant),  32'b00100);
    check("s1_ready_t1",  32'(in_ready),  32'b00100);
    check("s1_ovalid_t1", 32'(out_valid), 32'd0);
    @(negedge noc_clk);
    drive(2, 1, 1, 0, 0, 1, 16'hA002);
    #1;
    check("s1_ovalid_t2", 32'(out_valid), 32'd1);
    check("s1_oflit_t2",  32'(out_flit),  32'hA001);
    check("s1_ovc_t2",    32'(out_vc),    32'd1);
    check("s1_ready_t2",  32'(in_ready),  32'b00100);
    @(negedge noc_clk);
    drive(2, 1, 1, 0, 1, 1, 16'hA003);
    #1;
    check("s1_oflit_t3",  32'(out_flit),  32'hA002);
    @(negedge noc_clk);
    clear_inputs();
    #1;
    check("s1_ovalid_t4", 32'(out_valid), 32'd1);
    check("s1_oflit_t4",  32'(out_flit),  32'hA003);
    check("s1_grant_t4",  32'(in_grant),  32'd0);
    check("s1_cred1",     cred(1),        32'd1);
    check("s1_cred0",     cred(0),        32'd4);
    @(negedge noc_clk); #1;
    check("s1_ovalid_t5", 32'(out_valid), 32'd0);
    @(negedge noc_clk);
    credit_return = 2'b10;
    repeat (3) @(negedge noc_clk);
    credit_return = 2'b00;
    #1;
    check("s1_cred1_back", cred(1), 32'd4);

    // ---- fairness: inputs 0 (VC0), 1 (VC1), 4 (VC0), single-flit packets ----
    do_reset();
    for (int c = 0; c < 13; c++) begin
      @(negedge noc_clk);
      if (c < 12) begin
        drive(0, 1, 1, 1, 1, 0, 16'hC000);
        drive(1, 1, 1, 1, 1, 1, 16'hC001);
        drive(4, 1, 1, 1, 1, 0, 16'hC004);
      end else begin
        clear_inputs();
      end
      #1;
      if (c % 2 == 1) begin
        check($sformatf("fair_grant_c%0d", c), 32'(in_grant), 32'(1) << who(c / 2));
        check($sformatf("fair_ready_c%0d", c), 32'(in_ready), 32'(1) << who(c / 2));
      end else begin
        check($sformatf("fair_bubble_c%0d", c), 32'(in_grant), 32'd0);
      end
      check($sformatf("fair_ovalid_c%0d", c), 32'(out_valid),
            ((c >= 2) && (c % 2 == 0)) ? 32'd1 : 32'd0);
      if ((c >= 2) && (c % 2 == 0)) begin
        check($sformatf("fair_oflit_c%0d", c), 32'(out_flit),
              32'hC000 + 32'(who((c - 2) / 2)));
        check($sformatf("fair_ovc_c%0d", c), 32'(out_vc),
              (who((c - 2) / 2) == 1) ? 32'd1 : 32'd0);
      end
    end
    check("fair_cred0",  cred(0),             32'd0);
    check("fair_cred1",  cred(1),             32'd2);
    check("fair_cavail", 32'(credit_avail),   32'b10);

    // ---- VC skip: VC0 empty, input0 wants VC0, input3 wants VC1 -------------
    @(negedge noc_clk);
    drive(0, 1, 1, 1, 1, 0, 16'hD000);
    drive(3, 1, 1, 1, 0, 1, 16'hD300);
    #1;
    check("skip_grant_c0",  32'(in_grant),     32'd0);
    check("skip_cavail_c0", 32'(credit_avail), 32'b10);
    @(negedge noc_clk);
    credit_return = 2'b01;
    #1;
    check("skip_grant_c1", 32'(in_grant), 32'b01000);
    check("skip_ready_c1", 32'(in_ready), 32'b01000);
    @(negedge noc_clk);
    credit_return = 2'b00;
    drive(3, 1, 1, 0, 1, 1, 16'hD301);
    #1;
    check("skip_grant_c2", 32'(in_grant), 32'b01000);
    check("skip_oflit_c2", 32'(out_flit), 32'hD300);
    check("skip_ovc_c2",   32'(out_vc),   32'd1);
    @(negedge noc_clk);
    drive(3, 0, 0, 0, 0, 1, 16'h0000);
    #1;
    check("skip_grant_c3",  32'(in_grant),     32'd0);
    check("skip_cavail_c3", 32'(credit_avail), 32'b01);
    check("skip_oflit_c3",  32'(out_flit),     32'hD301);
    @(negedge noc_clk); #1;
    check("skip_grant_c4", 32'(in_grant), 32'b00001);
    check("skip_ready_c4", 32'(in_ready), 32'b00001);
    @(negedge noc_clk);
    clear_inputs();
    #1;
    check("skip_ovalid_c5", 32'(out_valid), 32'd1);
    check("skip_oflit_c5",  32'(out_flit),  32'hD000);
    check("skip_ovc_c5",    32'(out_vc),    32'd0);

    // ---- credit stall: input1, VC0, 6 flits, 4 credits ----------------------
    do_reset();
    k       = 0;
    prev_er = 1'b0;
    for (int c = 0; c < 11; c++) begin
      @(negedge noc_clk);
      credit_return = ((c == 7) || (c == 8)) ? 2'b01 : 2'b00;
      if (k < 6) begin
        drive(1, 1, 1, (k == 0), (k == 5), 0, 16'(32'hB000 + k));
      end else begin
        clear_inputs();
      end
      #1;
      er = ((c >= 1) && (c <= 4)) || (c == 8) || (c == 9);
      check($sformatf("stall_ready_c%0d", c), 32'(in_ready), er ? 32'b00010 : 32'd0);
      check($sformatf("stall_ovalid_c%0d", c), 32'(out_valid), 32'(prev_er));
      if (prev_er) begin
        check($sformatf("stall_oflit_c%0d", c), 32'(out_flit), 32'hB000 + 32'(k - 1));
      end
      if (c == 6) begin
        check("stall_grant_held", 32'(in_grant),     32'b00010);
        check("stall_cavail",     32'(credit_avail), 32'b10);
      end
      if (c == 10) begin
        check("stall_released", 32'(in_grant), 32'd0);
        check("stall_cred0",    cred(0),        32'd0);
      end
      prev_er = er;
      if (er) k++;
    end
    credit_return = 2'b00;

    // ---- simultaneous spend/return and over-return --------------------------
    do_reset();
    @(negedge noc_clk);
    drive(2, 1, 1, 1, 0, 1, 16'hE000);
    #1;
    check("sim_grant_c0", 32'(in_grant), 32'd0);
    @(negedge noc_clk); #1;
    check("sim_ready_c1", 32'(in_ready), 32'b00100);
    @(negedge noc_clk);
    drive(2, 1, 1, 0, 0, 1, 16'hE001);
    @(negedge noc_clk);
    drive(2, 1, 1, 0, 1, 1, 16'hE002);
    credit_return = 2'b10;
    #1;
    check("sim_cred1_pre", cred(1),        32'd2);
    check("sim_ready_c3",  32'(in_ready),  32'b00100);
    @(negedge noc_clk);
    clear_inputs();
    credit_return = 2'b00;
    #1;
    check("sim_cred1_hold", cred(1),        32'd2);
    check("sim_oflit_c4",   32'(out_flit),  32'hE002);
    check("sim_err_c4",     32'(credit_err), 32'd0);
    @(negedge noc_clk);
    credit_return = 2'b10;
    repeat (2) @(negedge noc_clk);
    #1;
    check("sim_cred1_full", cred(1), 32'd4);
    @(negedge noc_clk);
    credit_return = 2'b00;
    #1;
    check("sim_cred1_sat", cred(1),         32'd4);
    check("sim_over_err",  32'(credit_err), 32'(EXP_OVER_ERR));

    // ---- reset mid-packet: input1, VC0, reset during flit 2 of 5 -------------
    do_reset();
    check("mrst_err_clr", 32'(credit_err), 32'd0);
    @(negedge noc_clk);
    drive(1, 1, 1, 1, 0, 0, 16'hF000);
    @(negedge noc_clk); #1;
    check("mrst_ready_c1", 32'(in_ready), 32'b00010);
    @(negedge noc_clk);
    drive(1, 1, 1, 0, 0, 0, 16'hF001);
    #1;
    check("mrst_ovalid_c2", 32'(out_valid), 32'd1);
    check("mrst_cred0_c2",  cred(0),        32'd3);
    noc_rst = 1'b1;
    #1;
    check("mrst_async_grant",  32'(in_grant),  32'd0);
    check("mrst_async_ovalid", 32'(out_valid), 32'd0);
    @(negedge noc_clk);
    noc_rst = 1'b0;
    #1;
    check("mrst_state",  32'(dut.r_state),    32'd0);
    check("mrst_grant",  32'(in_grant),       32'd0);
    check("mrst_ovalid", 32'(out_valid),      32'd0);
    check("mrst_oflit",  32'(out_flit),       32'd0);
    check("mrst_cavail", 32'(credit_avail),   32'b11);
    check("mrst_cred0",  cred(0),             32'd4);
    check("mrst_cred1",  cred(1),             32'd4);
    @(negedge noc_clk); #1;
    check("mrst_regrant", 32'(in_grant), 32'b00010);
    @(negedge noc_clk);
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
